// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM state and symbol encodings for the Morse keyer capture block.
package morse_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;
endpackage

// File: rtl/morse_edge_det.sv
// morse_edge_det: per-bit rise/fall detector against a registered copy of each input.
module morse_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [W-1:0] prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prev <= '0;
        else        prev <= level;
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/morse_keyer_capture.sv
// morse_keyer_capture: assembles one Morse character from key presses and offers it
// to the decoder over a valid/ready handshake.
module morse_keyer_capture
    import morse_pkg::*;
#(
    parameter  int MAX_LEN    = 5,
    parameter  int TIMED      = 1,
    parameter  int DASH_TICKS = 3,
    parameter  int GAP_TICKS  = 7,
    parameter  int CNT_W      = 8,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               btn_key,
    input  logic               btn_dot,
    input  logic               btn_dash,
    input  logic               btn_enter,
    output logic [MAX_LEN-1:0] out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dropped
);
    state_t             state, next_state;
    logic [3:0]         rise, fall;
    logic [CNT_W-1:0]   cnt;
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
    logic               ovf;
    logic               key_rise, key_fall, dot_rise, dash_rise, btn_sym, enter_rise, gap_done;
    logic               do_append, sym, cnt_clr, unused_fall;

    morse_edge_det #(.W(4)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({btn_enter, btn_dash, btn_dot, btn_key}),
        .rise  (rise),
        .fall  (fall)
    );

    assign unused_fall = ^fall[3:1];
    assign key_rise    = (TIMED != 0) && rise[0];
    assign key_fall    = (TIMED != 0) && fall[0];
    assign dot_rise    = (TIMED == 0) && rise[1];
    assign dash_rise   = (TIMED == 0) && rise[2];
    assign btn_sym     = dot_rise || dash_rise;
    assign enter_rise  = rise[3];
    assign gap_done    = tick && (int'(cnt) == GAP_TICKS - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;

    // A symbol edge and an enter edge in the same cycle close the character with that symbol.
    always_comb begin
        next_state = state;
        do_append  = 1'b0;
        sym        = SYM_DOT;
        cnt_clr    = 1'b0;
        case (state)
            IDLE:
                if (key_rise) begin
                    next_state = PRESS;
                    cnt_clr    = 1'b1;
                end else if (btn_sym) begin
                    do_append  = 1'b1;
                    sym        = dot_rise ? SYM_DOT : SYM_DASH;
                    cnt_clr    = 1'b1;
                    next_state = enter_rise ? EMIT : GAP;
                end
            PRESS:
                if (key_fall) begin
                    do_append  = 1'b1;
                    sym        = (int'(cnt) >= DASH_TICKS) ? SYM_DASH : SYM_DOT;
                    cnt_clr    = 1'b1;
                    next_state = enter_rise ? EMIT : GAP;
                end
            GAP:
                if (key_rise) begin
                    next_state = PRESS;
                    cnt_clr    = 1'b1;
                end else if (btn_sym) begin
                    do_append  = 1'b1;
                    sym        = dot_rise ? SYM_DOT : SYM_DASH;
                    cnt_clr    = 1'b1;
                    next_state = enter_rise ? EMIT : GAP;
                end else if (enter_rise || gap_done) begin
                    next_state = EMIT;
                end
            EMIT:
                next_state = out_ready ? IDLE : EMIT;
            default:
                next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = state == EMIT;
        dropped   = (state == EMIT) && (key_rise || btn_sym);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            code <= '0;
            len  <= '0;
            ovf  <= 1'b0;
            cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                code <= '0;
                len  <= '0;
                ovf  <= 1'b0;
            end else if (do_append) begin
                if (len == LEN_W'(MAX_LEN)) ovf <= 1'b1;
                else begin
                    code <= MAX_LEN'({code, sym});
                    len  <= len + LEN_W'(1);
                end
            end
            cnt <= cnt_clr ? '0 :
                   (tick && (state == PRESS || state == GAP) && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
        end

    assign out_code = code;
    assign out_len  = len;
    assign out_ovf  = ovf;
endmodule

// File: tb/tb_morse_keyer_capture.sv
// tb_morse_keyer_capture: scoreboard bench driving a timed-key and a button-mode instance side by side.
module tb_morse_keyer_capture;
    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic btn_key = 1'b0, btn_dot = 1'b0, btn_dash = 1'b0, btn_enter = 1'b0, out_ready = 1'b1;
    logic [4:0] a_code, b_code;
    logic [2:0] a_len, b_len;
    logic a_ovf, b_ovf, a_valid, b_valid, a_drop, b_drop;

    typedef struct {logic b; logic [4:0] code; logic [2:0] len; logic ovf;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_pass = 0, hs = 0, drops = 0;

    always #5 clk = ~clk;

    morse_keyer_capture #(.TIMED(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_key(btn_key), .btn_dot(btn_dot),
        .btn_dash(btn_dash), .btn_enter(btn_enter), .out_code(a_code), .out_len(a_len),
        .out_ovf(a_ovf), .out_valid(a_valid), .out_ready(out_ready), .dropped(a_drop)
    );

    morse_keyer_capture #(.TIMED(0)) u_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_key(btn_key), .btn_dot(btn_dot),
        .btn_dash(btn_dash), .btn_enter(btn_enter), .out_code(b_code), .out_len(b_len),
        .out_ovf(b_ovf), .out_valid(b_valid), .out_ready(out_ready), .dropped(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        else n_pass++;
    endtask

    always @(negedge clk) if (rst_n) begin
        if (a_drop || b_drop) drops++;
        if (out_ready && (a_valid || b_valid)) begin
            hs++;
            if (q.size() == 0) chk("unexpected_char", 1, 0);
            else begin
                e = q.pop_front();
                chk("which_dut", {31'd0, b_valid}, {31'd0, e.b});
                chk("code", b_valid ? b_code : a_code, e.code);
                chk("len", b_valid ? b_len : a_len, e.len);
                chk("ovf", b_valid ? b_ovf : a_ovf, e.ovf);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic key(input int ticks);
        btn_key = 1'b1; cyc(1);
        tk(ticks);
        btn_key = 1'b0; cyc(1);
    endtask

    task automatic bpress(input logic d, input logic s);
        btn_dot = d; btn_dash = s; cyc(1);
        btn_dot = 1'b0; btn_dash = 1'b0; cyc(1);
    endtask

    task automatic enter();
        btn_enter = 1'b1; cyc(1);
        btn_enter = 1'b0; cyc(1);
    endtask

    task automatic push(input logic b, input logic [4:0] c, input logic [2:0] l, input logic o);
        exp_t x;
        x.b = b; x.code = c; x.len = l; x.ovf = o;
        q.push_back(x);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1);
        chk(tag, q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && !a_valid; i++) cyc(1);
        chk(tag, {31'd0, a_valid}, 1);
    endtask

    initial begin
        logic stable;
        int hs0;
        #2;
        chk("rst_valid", {a_valid, b_valid}, 0);
        chk("rst_len", {a_len, b_len}, 0);
        chk("rst_code", {a_code, b_code}, 0);
        chk("rst_misc", {a_ovf, b_ovf, a_drop, b_drop}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // 1: dot, gap, dash, then gap timeout -> 'A'
        push(0, 5'b00001, 3'd2, 0);
        key(1); tk(1); key(3);
        chk("t1_before_gap", {31'd0, a_valid}, 0);
        tk(7);
        drain("t1_drain");

        // 2: six dots overflow, enter closes; valid the cycle after the enter edge
        push(0, 5'b00000, 3'd5, 1);
        for (int i = 0; i < 6; i++) key(1);
        btn_enter = 1'b1;
        @(negedge clk); chk("t2_valid_early", {31'd0, a_valid}, 0);
        @(negedge clk); chk("t2_valid_next", {31'd0, a_valid}, 1);
        cyc(1); btn_enter = 1'b0; cyc(1);
        drain("t2_drain");

        // 3: backpressure with two dropped presses
        out_ready = 1'b0;
        push(0, 5'b00001, 3'd1, 0);
        key(3); enter();
        wait_valid("t3_valid");
        drops = 0; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 5) btn_key = 1'b1;
            if (i == 3 || i == 7) btn_key = 1'b0;
            cyc(1);
            stable &= a_valid && a_code == 5'b00001 && a_len == 3'd1;
        end
        chk("t3_stable", {31'd0, stable}, 1);
        chk("t3_drops", drops, 2);
        out_ready = 1'b1;
        cyc(1);
        chk("t3_idle_len", a_len, 0);
        chk("t3_idle_valid", {31'd0, a_valid}, 0);
        drain("t3_drain");

        // 4: button mode, dot wins over a simultaneous dash
        push(1, 5'b01010, 3'd4, 0);
        bpress(0, 1); bpress(1, 0); bpress(0, 1); bpress(1, 1);
        enter();
        drain("t4a_drain");
        push(1, 5'b10100, 3'd5, 0);
        bpress(0, 1); bpress(1, 0); bpress(0, 1); bpress(1, 0); bpress(1, 0);
        enter();
        drain("t4b_drain");

        // 5: reset mid-PRESS and in EMIT aborts without emitting
        hs0 = hs;
        key(1);
        btn_key = 1'b1; cyc(2);
        #2 rst_n = 1'b0;
        #1 chk("t5_press_len", a_len, 0);
        btn_key = 1'b0;
        cyc(1); rst_n = 1'b1; cyc(1);
        out_ready = 1'b0;
        key(1); enter();
        wait_valid("t5_emit_valid");
        #2 rst_n = 1'b0;
        #1 chk("t5_emit_out", {a_valid, a_len, a_code, a_ovf}, 0);
        out_ready = 1'b1;
        cyc(1); rst_n = 1'b1; cyc(3);
        chk("t5_no_emit", hs - hs0, 0);
        push(0, 5'b00001, 3'd1, 0);
        key(3); tk(7);
        drain("t5_clean");

        // 6: enter with nothing keyed is ignored; fall+enter includes the symbol
        hs0 = hs;
        enter(); cyc(20);
        chk("t6_idle_enter", hs - hs0, 0);
        push(0, 5'b00010, 3'd2, 0);
        key(3);
        btn_key = 1'b1; cyc(1); tk(1);
        btn_key = 1'b0; btn_enter = 1'b1;
        @(negedge clk); chk("t6_valid_early", {31'd0, a_valid}, 0);
        @(negedge clk); chk("t6_valid_next", {31'd0, a_valid}, 1);
        cyc(1); btn_enter = 1'b0; cyc(1);
        drain("t6_drain");

        // 7: DASH_TICKS-1 is a dot; a press past counter saturation is still a dash
        push(0, 5'b00001, 3'd2, 0);
        key(2); key(300); enter();
        drain("t7_drain");

        cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
